// File: rtl/ring_buffer_ctrl.sv
// Address and flow-control controller for a circular event buffer held in external RAM.
// Optional almost-full flag is compiled in when RBC_ALMOST_FULL_EN is defined.
module ring_buffer_ctrl #(
  parameter int AW = 18,
  parameter int RW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [AW-1:0] limit,
  input  logic          flush,
  input  logic          err_clr,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  input  logic          rd_req,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          rd_data_valid,
  output logic [RW-1:0] n1,
  output logic [RW-1:0] n2,
  output logic [AW-1:0] usage,
  output logic          full,
  output logic          empty,
  output logic [1:0]    error
`ifdef RBC_ALMOST_FULL_EN
  ,
  input  logic [AW-1:0] af_thresh,
  output logic          almost_full
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] limit_q, limit_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [RW-1:0] n1_q, n1_d;
  logic [RW-1:0] n2_q, n2_d;
  logic [AW-1:0] usage_q, usage_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          wr_ready_q, wr_ready_d;
  logic          rd_valid_q;
  logic [1:0]    error_q, error_d;
  logic          in_run;
  logic          flush_exit;

`ifdef RBC_ALMOST_FULL_EN
  logic af_q, af_d;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values; combinational blocks below use blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next-state logic; flush takes priority over dropping enable.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN: begin
        if (flush)        state_d = ST_FLUSH;
        else if (!enable) state_d = ST_IDLE;
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. Strobes are gated by reset so none escapes in the reset cycle.
  always_comb begin
    in_run     = (state_q == ST_RUN);
    flush_exit = (state_q == ST_FLUSH);
    wr_en      = in_run & wr_valid & wr_ready_q & ~reset;
    rd_en      = in_run & rd_req & ~empty_q & ~reset;
  end

  // ---------------------------------------------------------------------------
  // Pointers and round counters
  // ---------------------------------------------------------------------------
  always_comb begin
    limit_d = limit_q;
    if (state_q == ST_IDLE && enable) limit_d = limit;

    wr_addr_d = wr_addr_q;
    n1_d      = n1_q;
    if (wr_en) begin
      if (wr_addr_q == limit_q - AW'(1)) begin
        wr_addr_d = '0;
        n1_d      = n1_q + RW'(1);
      end else begin
        wr_addr_d = wr_addr_q + AW'(1);
      end
    end

    rd_addr_d = rd_addr_q;
    n2_d      = n2_q;
    if (rd_en) begin
      if (rd_addr_q == limit_q - AW'(1)) begin
        rd_addr_d = '0;
        n2_d      = n2_q + RW'(1);
      end else begin
        rd_addr_d = rd_addr_q + AW'(1);
      end
    end

    // Leaving FLUSH the reader jumps onto the writer, discarding everything.
    if (flush_exit) begin
      rd_addr_d = wr_addr_q;
      n2_d      = n1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy, flags and errors
  // ---------------------------------------------------------------------------
  always_comb begin
    usage_d = usage_q;
    unique case ({wr_en, rd_en})
      2'b10:   usage_d = usage_q + AW'(1);
      2'b01:   usage_d = usage_q - AW'(1);
      default: usage_d = usage_q;
    endcase
    if (flush_exit) usage_d = '0;

    // limit_q is zero only before the first run; it must not read as full then.
    full_d  = (limit_d != '0) && (usage_d == limit_d);
    empty_d = (usage_d == '0);

    // Ready only while RUN persists, so it stays low in IDLE and FLUSH.
    wr_ready_d = (state_q == ST_RUN) && (state_d == ST_RUN) && !full_d;

    error_d = err_clr ? 2'b00 : error_q;
    error_d = error_d | {in_run & rd_req & empty_q, in_run & wr_valid & full_q};
  end

`ifdef RBC_ALMOST_FULL_EN
  always_comb begin
    af_d = flush_exit ? 1'b0 : (usage_d >= af_thresh);
  end
`endif

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      limit_q    <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      n1_q       <= '0;
      n2_q       <= '0;
      usage_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      wr_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      error_q    <= 2'b00;
    end else begin
      limit_q    <= limit_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      n1_q       <= n1_d;
      n2_q       <= n2_d;
      usage_q    <= usage_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      wr_ready_q <= wr_ready_d;
      rd_valid_q <= rd_en;
      error_q    <= error_d;
    end
  end

`ifdef RBC_ALMOST_FULL_EN
  always_ff @(posedge clk) begin
    if (reset) af_q <= 1'b0;
    else       af_q <= af_d;
  end

  assign almost_full = af_q;
`endif

  assign wr_ready      = wr_ready_q;
  assign wr_addr       = wr_addr_q;
  assign rd_addr       = rd_addr_q;
  assign rd_data_valid = rd_valid_q;
  assign n1            = n1_q;
  assign n2            = n2_q;
  assign usage         = usage_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign error         = error_q;

endmodule

// File: tb/tb_ring_buffer_ctrl.sv
// Self-checking bench for ring_buffer_ctrl: directed scenarios plus randomized traffic
// compared each cycle against a word-count reference model.
module tb_ring_buffer_ctrl;

  localparam int AW = 6;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [AW-1:0] limit;
  logic          flush;
  logic          err_clr;
  logic          wr_valid;
  logic          wr_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_req;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_data_valid;
  logic [RW-1:0] n1;
  logic [RW-1:0] n2;
  logic [AW-1:0] usage;
  logic          full;
  logic          empty;
  logic [1:0]    error;
`ifdef RBC_ALMOST_FULL_EN
  logic [AW-1:0] af_thresh;
  logic          almost_full;
`endif

  always #5 clk = ~clk;

  ring_buffer_ctrl #(.AW(AW), .RW(RW)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .limit         (limit),
    .flush         (flush),
    .err_clr       (err_clr),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .rd_req        (rd_req),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data_valid (rd_data_valid),
    .n1            (n1),
    .n2            (n2),
    .usage         (usage),
    .full          (full),
    .empty         (empty),
    .error         (error)
`ifdef RBC_ALMOST_FULL_EN
    ,
    .af_thresh     (af_thresh),
    .almost_full   (almost_full)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: absolute word counts; addresses and rounds follow by division.
  typedef enum {M_IDLE, M_RUN, M_FLUSH} mode_t;
  mode_t      mode;
  int         run_age;
  int         lim;
  int         w_idx;
  int         r_idx;
  logic [1:0] m_err;
  logic       m_rdv;
  logic       m_af;

  function automatic int occ();
    return w_idx - r_idx;
  endfunction

  function automatic bit m_full();
    return (lim != 0) && (occ() == lim);
  endfunction

  function automatic bit m_empty();
    return occ() == 0;
  endfunction

  function automatic bit m_ready();
    return (mode == M_RUN) && (run_age >= 1) && !m_full();
  endfunction

  function automatic int addr_of(input int idx);
    return (lim == 0) ? 0 : idx % lim;
  endfunction

  function automatic int round_of(input int idx);
    return (lim == 0) ? 0 : (idx / lim) % (1 << RW);
  endfunction

  task automatic model_reset();
    mode = M_IDLE; run_age = 0; lim = 0; w_idx = 0; r_idx = 0;
    m_err = 2'b00; m_rdv = 1'b0; m_af = 1'b0;
  endtask

  task automatic model_update(input bit we, input bit re);
    bit s0, s1, fx;
    if (reset) begin
      model_reset();
      return;
    end
    s0 = (mode == M_RUN) && wr_valid && m_full();
    s1 = (mode == M_RUN) && rd_req && m_empty();
    fx = (mode == M_FLUSH);
    if (we) w_idx++;
    if (re) r_idx++;
    m_err = (err_clr ? 2'b00 : m_err) | {s1, s0};
    m_rdv = re;
    case (mode)
      M_IDLE: if (enable) begin mode = M_RUN; lim = int'(limit); run_age = 0; end
      M_RUN: begin
        if (flush)        mode = M_FLUSH;
        else if (!enable) mode = M_IDLE;
        else              run_age++;
      end
      default: begin mode = M_RUN; run_age = 0; r_idx = w_idx; end
    endcase
`ifdef RBC_ALMOST_FULL_EN
    m_af = fx ? 1'b0 : (occ() >= int'(af_thresh));
`else
    m_af = fx ? 1'b0 : m_af;
`endif
  endtask

  task automatic check_regs();
    check("wr_addr", 32'(wr_addr), addr_of(w_idx));
    check("rd_addr", 32'(rd_addr), addr_of(r_idx));
    check("n1", 32'(n1), round_of(w_idx));
    check("n2", 32'(n2), round_of(r_idx));
    check("usage", 32'(usage), occ());
    check("full", 32'(full), 32'(m_full()));
    check("empty", 32'(empty), 32'(m_empty()));
    check("wr_ready", 32'(wr_ready), 32'(m_ready()));
    check("rd_data_valid", 32'(rd_data_valid), 32'(m_rdv));
    check("error", 32'(error), 32'(m_err));
`ifdef RBC_ALMOST_FULL_EN
    check("almost_full", 32'(almost_full), 32'(m_af));
`endif
  endtask

  // One clock: strobes checked mid-cycle, registers checked just after the edge.
  task automatic tick();
    bit exp_we, exp_re;
    #1;
    exp_we = !reset && (mode == M_RUN) && m_ready() && wr_valid;
    exp_re = !reset && (mode == M_RUN) && rd_req && !m_empty();
    check("wr_en", 32'(wr_en), 32'(exp_we));
    check("rd_en", 32'(rd_en), 32'(exp_re));
    @(posedge clk);
    model_update(exp_we, exp_re);
    #1;
    check_regs();
  endtask

  task automatic drive(input bit en, input bit fl, input bit wv, input bit rq, input bit ec);
    enable = en; flush = fl; wr_valid = wv; rd_req = rq; err_clr = ec;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  task automatic start_run(input int l);
    limit = AW'(l);
    drive(1, 0, 0, 0, 0);
    tick();
    tick();
  endtask

  initial begin
    int wp, rp;
    model_reset();
    reset = 1'b1;
    limit = AW'(8);
    drive(0, 0, 0, 0, 0);
`ifdef RBC_ALMOST_FULL_EN
    af_thresh = AW'(3);
`endif

    // Reset values
    do_reset();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_ready", 32'(wr_ready), 32'd0);

    // Basic writes, including the two-cycle enable latency
    start_run(8);
    check("en_latency_ready", 32'(wr_ready), 32'd1);
    drive(1, 0, 1, 0, 0);
    repeat (5) tick();
    drive(1, 0, 0, 0, 0);
    check("basic_usage", 32'(usage), 32'd5);
    check("basic_wr_addr", 32'(wr_addr), 32'd5);
    check("basic_empty", 32'(empty), 32'd0);

    // Fill, overflow and clear
    do_reset();
    start_run(4);
    drive(1, 0, 1, 0, 0);
    repeat (4) tick();
    check("fill_full", 32'(full), 32'd1);
    check("fill_ready", 32'(wr_ready), 32'd0);
    tick();
    check("ovf_error", 32'(error), 32'd1);
    drive(1, 0, 0, 0, 1);
    tick();
    check("err_clr", 32'(error), 32'd0);

    // Read and write together while full
    drive(1, 0, 1, 1, 0);
    tick();
    check("rwfull_usage", 32'(usage), 32'd3);
    check("rwfull_ready", 32'(wr_ready), 32'd1);
    drive(1, 0, 1, 0, 0);
    tick();
    check("rwfull_refill", 32'(usage), 32'd4);

    // Flush with three words held, then underflow
    drive(1, 0, 0, 1, 1);
    tick();
    check("pre_flush_usage", 32'(usage), 32'd3);
    drive(1, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0);
    tick();
    check("flush_rd_addr", 32'(rd_addr), 32'd1);
    check("flush_n2", 32'(n2), 32'd1);
    check("flush_empty", 32'(empty), 32'd1);
    drive(1, 0, 0, 1, 0);
    tick();
    check("udf_error", 32'(error), 32'd2);

    // Wrap: ten writes interleaved with ten reads
    do_reset();
    start_run(4);
    for (int c = 0; c < 60 && (w_idx < 10 || r_idx < 10); c++) begin
      drive(1, 0, w_idx < 10, (r_idx < 10) && (r_idx < w_idx), 0);
      tick();
    end
    drive(1, 0, 0, 0, 0);
    check("wrap_n1", 32'(n1), 32'd2);
    check("wrap_n2", 32'(n2), 32'd2);
    check("wrap_wr_addr", 32'(wr_addr), 32'd2);
    check("wrap_rd_addr", 32'(rd_addr), 32'd2);
    check("wrap_usage", 32'(usage), 32'd0);

    // Reset in the same cycle as a write
    do_reset();
    start_run(8);
    drive(1, 0, 1, 0, 0);
    repeat (6) tick();
    check("midrst_usage", 32'(usage), 32'd6);
    reset = 1'b1;
    #1;
    check("midrst_no_wr_en", 32'(wr_en), 32'd0);
    tick();
    reset = 1'b0;
    check("midrst_usage0", 32'(usage), 32'd0);
    check("midrst_wr_addr0", 32'(wr_addr), 32'd0);
    drive(0, 0, 1, 0, 0);
    tick();
    check("midrst_idle_ready", 32'(wr_ready), 32'd0);

    // Randomized traffic, one limit per phase; limit 2 exercises round wrap
    for (int p = 0; p < 6; p++) begin
      do_reset();
      limit = AW'((p == 0) ? 2 : $urandom_range(2, 12));
`ifdef RBC_ALMOST_FULL_EN
      af_thresh = AW'($urandom_range(0, 12));
`endif
      wp = $urandom_range(30, 80);
      rp = $urandom_range(30, 80);
      for (int c = 0; c < 400; c++) begin
        reset = ($urandom_range(0, 299) == 0);
        drive($urandom_range(0, 19) != 0,
              $urandom_range(0, 39) == 0,
              $urandom_range(0, 99) < wp,
              $urandom_range(0, 99) < rp,
              $urandom_range(0, 9) == 0);
        tick();
      end
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ring_buffer_ctrl.md
# ring_buffer_ctrl

Address and flow-control controller for a circular event buffer in external single-port-per-side RAM. It generates write and read addresses and strobes, wraps them at a programmable depth, and counts wrap rounds on each side. It tracks occupancy, full and empty, and latches overflow/underflow errors. Its pointer and round outputs feed the downstream occupancy monitor and the L2 readout logic.

## Interface
- `AW`, default 18: address / depth width
- `RW`, default 16: round-counter width
- `clk`  in  1: sole clock, rising edge
- `reset`  in  1: synchronous, active-high
- `enable`  in  1: run request; level-sensitive
- `limit`  in  AW: buffer depth in words; legal range 2..2^AW-1; sampled only on the IDLE->RUN transition
- `flush`  in  1: one-cycle pulse; discards all buffered data
- `err_clr`  in  1: clears `error`
- `wr_valid`  in  1: producer has a word
- `wr_ready`  out  1: registered; controller accepts a write
- `wr_en`  out  1: RAM write strobe, `wr_valid & wr_ready` (combinational)
- `wr_addr`  out  AW: registered write pointer
- `rd_req`  in  1: consumer requests a word
- `rd_en`  out  1: RAM read strobe (combinational)
- `rd_addr`  out  AW: registered read pointer
- `rd_data_valid`  out  1: RAM data valid, one cycle after `rd_en`
- `n1`, `n2`  out  RW each: write and read round counters
- `usage`  out  AW: registered occupancy in words
- `full`, `empty`  out  1 each: registered
- `error`  out  2: sticky; bit0 = overflow attempt, bit1 = underflow attempt

## Operation
- **States.** Three states: IDLE, RUN, FLUSH. Reset enters IDLE.
- **IDLE.**
  - No strobes; `wr_ready`=0.
  - `enable`=1 moves to RUN on the next cycle and latches `limit` into `limit_q`.
  - Pointers, rounds and occupancy are retained.
- **RUN.**
  - `enable`=0 moves to IDLE; a strobe presented in that same cycle still completes.
  - `flush`=1 moves to FLUSH.
  - If `flush` and `enable`=0 arrive in the same cycle, `flush` wins.
- **FLUSH.** Lasts exactly one cycle, then returns to RUN.
  - No strobes in this cycle.
  - On exit: `rd_addr`<=`wr_addr`, `n2`<=`n1`, `usage`<=0, `empty`<=1, `full`<=0.
- **Write.** `wr_en` asserts only in RUN with `wr_valid & wr_ready`. `wr_ready` = RUN & !`full` (registered).
- **Read.** `rd_en` = RUN & `rd_req` & !`empty`.
- **Pointer advance.** A pointer advances by one per strobe.
  - At `limit_q`-1 it wraps to 0 and its round counter increments.
  - Round counters wrap modulo 2^RW silently.
- **Occupancy.**
  - `usage` +1 on a write only, -1 on a read only, unchanged on both together.
  - `full` = (next `usage` == `limit_q`); `empty` = (next `usage` == 0).
- **Simultaneous read and write while full.** The read is performed. The write is not accepted, because `wr_ready` comes from the registered `full`. `wr_ready` rises the following cycle.
- **Errors.**
  - `error[0]` sets when `wr_valid` is high while in RUN with `full`=1.
  - `error[1]` sets when `rd_req` is high while in RUN with `empty`=1.
  - If `err_clr` and a new error condition occur in the same cycle, the set wins.
- **Reset.** Reset mid-operation abandons all in-flight state. No strobe is issued in the reset cycle.

## Timing
- **Reset values:**
  - State IDLE.
  - `wr_addr`, `rd_addr`, `n1`, `n2`, `usage` = 0.
  - `empty`=1, `full`=0, `wr_ready`=0, `rd_data_valid`=0, `error`=2'b00.
  - `limit_q`=0.
- **Write.** A write strobe at edge k presents `wr_addr`=A during cycle k. At k+1, `wr_addr`=A+1 (or 0 on wrap) and `usage` is updated.
- **Read.** `rd_en` at cycle k gives `rd_data_valid`=1 at k+1. `rd_addr` is updated at k+1.
- **Enable.** Latency from `enable` rising to the first possible `wr_en` is 2 cycles: one cycle to RUN, one cycle for `wr_ready` to register.
- **Throughput.** Sustained rate is one write and one read per cycle when neither full nor empty.

## Configuration
- **`RBC_ALMOST_FULL_EN` defined:**
  - Adds input `af_thresh` [AW] and output `almost_full`.
  - `almost_full` is registered and equals (next `usage` >= `af_thresh`); reset value 0.
  - FLUSH clears it.
- **`RBC_ALMOST_FULL_EN` undefined:** both ports and all associated logic are absent; all other behaviour is identical.

## Test plan
- **Basic writes.** `limit`=8, `enable`=1, 5 writes.
  - Required: `wr_addr` sequence 0..4, `usage`=5, `n1`=0, `empty`=0.
- **Fill, overflow and clear.** `limit`=4, write 4 words, then hold `wr_valid`.
  - Required: `full`=1 and `wr_ready`=0 from the cycle after the 4th write; `error`=2'b01.
  - Then pulse `err_clr`: `error`=0.
- **Wrap.** `limit`=4, 10 writes interleaved with 10 reads.
  - Required: `n1`=`n2`=2, `wr_addr`=`rd_addr`=2, `usage`=0.
  - `rd_data_valid` trails each `rd_en` by exactly 1 cycle.
- **Read/write while full.** `limit`=4, full, `rd_req` and `wr_valid` in the same cycle.
  - Required: the read occurs and the write does not; `usage`=3.
  - The next cycle has `wr_ready`=1 and the write is accepted; `usage` returns to 4.
- **Flush and underflow.** Flush with `usage`=3, then `rd_req`=1.
  - Required: `rd_addr`=`wr_addr`, `n2`=`n1`, `empty`=1, no `rd_en`, `error`=2'b10.
- **Reset mid-operation.** Reset in the same cycle as a write, with `usage`=6.
  - Required: no `wr_en`; all outputs at reset values the next cycle; state IDLE.
